// File: rtl/fp_divider_pkg.sv
// Shared constants and types for the single-precision divider datapath.
package fp_divider_pkg;
   localparam int BIAS   = 127;
   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int MANT_W = FRAC_W + 1;
   localparam int QUO_W  = 26;
   localparam logic [31:0] QNAN    = 32'h7FC00000;
   localparam logic [31:0] POS_INF = 32'h7F800000;

   typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM} state_e;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;
endpackage

// File: rtl/fp_divider_if.sv
// Request/response bundle between a requester and fp_divider.
interface fp_divider_if;
   logic        start;
   logic [31:0] inputA;
   logic [31:0] inputB;
   logic [31:0] result;
   logic        of;
   logic        uf;
   logic        dz;
   logic        busy;
   logic        done;

   modport master (output start, inputA, inputB,
                   input  result, of, uf, dz, busy, done);
   modport slave  (input  start, inputA, inputB,
                   output result, of, uf, dz, busy, done);
endinterface

// File: rtl/fp_mant_divider.sv
// Restoring mantissa divider: one quotient bit per step, first step taken at load.
module fp_mant_divider
   import fp_divider_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [MANT_W-1:0] mA,
   input  logic [MANT_W-1:0] mB,
   output logic [QUO_W-1:0]  q,
   output logic              rem_nz,
   output logic              valid
);
   logic [MANT_W:0]   rem_q, rem_d, step_rem;
   logic [MANT_W-1:0] div_q, step_div, diff;
   logic [QUO_W-1:0]  q_q;
   logic [4:0]        cnt_q;
   logic              ge;

   // Remainder stays below the divisor, so the difference fits MANT_W bits.
   always_comb begin
      step_rem = load ? {1'b0, mA} : rem_q;
      step_div = load ? mB : div_q;
      ge       = step_rem >= {1'b0, step_div};
      diff     = ge ? MANT_W'(step_rem - {1'b0, step_div}) : step_rem[MANT_W-1:0];
      rem_d    = {diff, 1'b0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         div_q <= '0;
         q_q   <= '0;
         cnt_q <= '0;
      end else if (load) begin
         rem_q <= rem_d;
         div_q <= mB;
         q_q   <= {{(QUO_W-1){1'b0}}, ge};
         cnt_q <= 5'(QUO_W - 1);
      end else if (cnt_q != 5'd0) begin
         rem_q <= rem_d;
         q_q   <= {q_q[QUO_W-2:0], ge};
         cnt_q <= cnt_q - 5'd1;
      end
   end

   assign q      = q_q;
   assign rem_nz = |rem_q;
   assign valid  = (cnt_q == 5'd0);
endmodule

// File: rtl/fp_divider.sv
// IEEE-754 single-precision divider: FSM, special-case decode, exponent, RNE rounding, flags.
module fp_divider
   import fp_divider_pkg::*;
(
   input  logic clk,
   input  logic rst,
   fp_divider_if.slave io
);
   state_e             state_q;
   logic [31:0]        result_q;
   logic               of_q, uf_q, dz_q, busy_q, done_q;
   logic               sign_q;
   logic signed [9:0]  exp_q;

   fp32_t a, b;
   logic  sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic  spec_hit, spec_dz;
   logic [31:0] spec_res;

   assign a      = io.inputA;
   assign b      = io.inputB;
   assign sgn    = a.sign ^ b.sign;
   assign a_nan  = (&a.exp) && (|a.frac);
   assign b_nan  = (&b.exp) && (|b.frac);
   assign a_inf  = (&a.exp) && !(|a.frac);
   assign b_inf  = (&b.exp) && !(|b.frac);
   assign a_zero = (a.exp == '0);
   assign b_zero = (b.exp == '0);

   always_comb begin
      spec_hit = 1'b1;
      spec_dz  = 1'b0;
      spec_res = QNAN;
      if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) spec_res = QNAN;
      else if (a_inf)            spec_res = {sgn, POS_INF[30:0]};
      else if (b_zero) begin
         spec_res = {sgn, POS_INF[30:0]};
         spec_dz  = 1'b1;
      end
      else if (a_zero | b_inf)   spec_res = {sgn, 31'b0};
      else                       spec_hit = 1'b0;
   end

   logic              load, m_valid, rem_nz;
   logic [QUO_W-1:0]  q;

   assign load = (state_q == S_IDLE) && io.start && !spec_hit;

   fp_mant_divider u_mdiv (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .mA     ({1'b1, a.frac}),
      .mB     ({1'b1, b.frac}),
      .q      (q),
      .rem_nz (rem_nz),
      .valid  (m_valid)
   );

   logic [MANT_W-1:0] m_raw;
   logic [MANT_W:0]   m_rnd;
   logic              guard, sticky;
   logic signed [9:0] e_d;
   logic [FRAC_W-1:0] frac_d;

   // q[25] is the 2^0 bit; a clear q[25] means the quotient is below 1.0.
   always_comb begin
      if (q[QUO_W-1]) begin
         m_raw  = q[QUO_W-1:2];
         guard  = q[1];
         sticky = q[0] | rem_nz;
         e_d    = exp_q;
      end else begin
         m_raw  = q[QUO_W-2:1];
         guard  = q[0];
         sticky = rem_nz;
         e_d    = exp_q - 10'sd1;
      end
      m_rnd  = {1'b0, m_raw} + (MANT_W+1)'(guard & (sticky | m_raw[0]));
      frac_d = m_rnd[FRAC_W-1:0];
      if (m_rnd[MANT_W]) begin
         frac_d = '0;
         e_d    = e_d + 10'sd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         of_q     <= 1'b0;
         uf_q     <= 1'b0;
         dz_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sign_q   <= 1'b0;
         exp_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: if (io.start) begin
               if (spec_hit) begin
                  result_q <= spec_res;
                  of_q     <= 1'b0;
                  uf_q     <= 1'b0;
                  dz_q     <= spec_dz;
                  done_q   <= 1'b1;
               end else begin
                  sign_q  <= sgn;
                  exp_q   <= $signed({2'b0, a.exp}) - $signed({2'b0, b.exp}) + 10'sd127;
                  busy_q  <= 1'b1;
                  state_q <= S_DIVIDE;
               end
            end
            S_DIVIDE: if (m_valid) state_q <= S_NORM;
            S_NORM: begin
               of_q <= 1'b0;
               uf_q <= 1'b0;
               dz_q <= 1'b0;
               if (e_d >= 10'sd255) begin
                  result_q <= {sign_q, POS_INF[30:0]};
                  of_q     <= 1'b1;
               end else if (e_d <= 10'sd0) begin
                  result_q <= {sign_q, 31'b0};
                  uf_q     <= 1'b1;
               end else begin
                  result_q <= {sign_q, e_d[7:0], frac_d};
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign io.result = result_q;
   assign io.of     = of_q;
   assign io.uf     = uf_q;
   assign io.dz     = dz_q;
   assign io.busy   = busy_q;
   assign io.done   = done_q;
endmodule

// File: tb/tb_fp_divider.sv
// Directed and random checks of fp_divider against an exact-integer RNE model.
module tb_fp_divider;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fp_divider_if dif();
   fp_divider dut (.clk(clk), .rst(rst), .io(dif));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Quotient formed by one wide integer division, then rounded to nearest-even.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [2:0] fl,
                                   output int lat);
      logic s, nA, nB, iA, iB, zA, zB, hi, g, st;
      int ea, eb, e;
      longint unsigned ma, mb, qf, rm, m;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      nA = (ea == 255) && (a[22:0] != 0);
      nB = (eb == 255) && (b[22:0] != 0);
      iA = (ea == 255) && (a[22:0] == 0);
      iB = (eb == 255) && (b[22:0] == 0);
      zA = (ea == 0);
      zB = (eb == 0);
      fl = 3'b000;
      lat = 0;
      r = 32'h0;
      if (nA || nB || (zA && zB) || (iA && iB)) r = 32'h7FC00000;
      else if (iA) r = {s, 31'h7F800000};
      else if (zB) begin r = {s, 31'h7F800000}; fl = 3'b001; end
      else if (zA || iB) r = {s, 31'h0};
      else begin
         lat = 27;
         ma = 64'h800000 | 64'(a[22:0]);
         mb = 64'h800000 | 64'(b[22:0]);
         qf = (ma << 40) / mb;
         rm = (ma << 40) % mb;
         hi = (qf >= (64'd1 << 40));
         e  = ea - eb + 127 - (hi ? 0 : 1);
         if (hi) begin
            m = qf >> 17; g = qf[16]; st = ((qf & 64'hFFFF) != 0) || (rm != 0);
         end else begin
            m = qf >> 16; g = qf[15]; st = ((qf & 64'h7FFF) != 0) || (rm != 0);
         end
         if (g && (st || m[0])) m = m + 1;
         if (m == (64'd1 << 24)) begin m = 64'd1 << 23; e = e + 1; end
         if (e >= 255)    begin r = {s, 31'h7F800000}; fl = 3'b100; end
         else if (e <= 0) begin r = {s, 31'h0};        fl = 3'b010; end
         else begin
            logic [7:0] e8;
            e8 = 8'(e);
            r = {s, e8, m[22:0]};
         end
      end
   endfunction

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      dif.start  = 1'b1;
      dif.inputA = a;
      dif.inputB = b;
      @(posedge clk); #1;
      dif.start  = 1'b0;
      dif.inputA = $urandom;
      dif.inputB = $urandom;
   endtask

   // Counts edges after acceptance until done; optional stray start at inject_at.
   task automatic wait_done(input int inject_at, output int lat, output logic busy_ok);
      lat = 0;
      busy_ok = 1'b1;
      while (dif.done !== 1'b1 && lat < 40) begin
         if (dif.busy !== 1'b1) busy_ok = 1'b0;
         if (lat == inject_at) begin
            dif.start = 1'b1; dif.inputA = 32'h3F800000; dif.inputB = 32'h40400000;
         end
         @(posedge clk); #1;
         dif.start = 1'b0;
         lat++;
      end
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic [2:0] efl, input int elat);
      int lat;
      logic bok;
      issue(a, b);
      wait_done(-1, lat, bok);
      chk({tag, ".lat"}, 32'(lat), 32'(elat));
      chk({tag, ".res"}, dif.result, er);
      chk({tag, ".flags"}, {29'b0, dif.of, dif.uf, dif.dz}, {29'b0, efl});
      @(posedge clk); #1;
      chk({tag, ".done_pulse"}, {31'b0, dif.done}, 32'h0);
   endtask

   logic [31:0] specials [6] = '{32'h0, 32'h80000000, 32'h7F800000,
                                 32'hFF800000, 32'h7FC00000, 32'h00400000};

   function automatic logic [31:0] rnd_op();
      logic [7:0] e;
      if ($urandom_range(7) == 0) return specials[$urandom_range(5)];
      e = ($urandom_range(1) == 0) ? 8'($urandom_range(100, 154)) : 8'($urandom_range(1, 254));
      return {1'($urandom), e, 23'($urandom)};
   endfunction

   initial begin
      int lat, d1, d2, ndone;
      logic bok;
      logic [31:0] ra, rb, er;
      logic [2:0] efl;
      int elat;

      rst = 1'b1;
      dif.start = 1'b0; dif.inputA = '0; dif.inputB = '0;
      repeat (3) @(posedge clk); #1;
      chk("rst.result", dif.result, 32'h0);
      chk("rst.flags", {29'b0, dif.of, dif.uf, dif.dz}, 32'h0);
      chk("rst.busy", {31'b0, dif.busy}, 32'h0);
      chk("rst.done", {31'b0, dif.done}, 32'h0);
      rst = 1'b0;

      issue(32'h40E00000, 32'h40000000);
      wait_done(-1, lat, bok);
      chk("7/2.lat", 32'(lat), 32'd27);
      chk("7/2.busy", {31'b0, bok}, 32'h1);
      chk("7/2.res", dif.result, 32'h40600000);
      chk("7/2.flags", {29'b0, dif.of, dif.uf, dif.dz}, 32'h0);

      run("1/3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 27);
      run("-7/2",    32'hC0E00000, 32'h40000000, 32'hC0600000, 3'b000, 27);
      run("1/0",     32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001, 0);
      run("0/0",     32'h00000000, 32'h00000000, 32'h7FC00000, 3'b000, 0);
      run("nan/1",   32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b000, 0);
      run("0/5",     32'h00000000, 32'h40A00000, 32'h00000000, 3'b000, 0);
      run("inf/inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b000, 0);
      run("-inf/2",  32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 0);
      run("1/inf",   32'h3F800000, 32'h7F800000, 32'h00000000, 3'b000, 0);
      run("ovf",     32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b100, 27);
      run("unf",     32'h00800000, 32'h40000000, 32'h00000000, 3'b010, 27);
      run("clr",     32'h40E00000, 32'h40000000, 32'h40600000, 3'b000, 27);

      // A start while busy must be dropped, not queued.
      issue(32'h40E00000, 32'h40000000);
      wait_done(4, lat, bok);
      chk("ign.lat", 32'(lat), 32'd27);
      chk("ign.res", dif.result, 32'h40600000);
      ndone = 0;
      repeat (32) begin @(posedge clk); #1; if (dif.done === 1'b1) ndone++; end
      chk("ign.no_second", 32'(ndone), 32'd0);

      issue(32'h3F800000, 32'h40400000);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort.busy", {31'b0, dif.busy}, 32'h0);
      chk("abort.result", dif.result, 32'h0);
      ndone = 0;
      repeat (35) begin @(posedge clk); #1; if (dif.done === 1'b1) ndone++; end
      chk("abort.no_done", 32'(ndone), 32'd0);

      @(negedge clk);
      dif.start = 1'b1; dif.inputA = 32'h40E00000; dif.inputB = 32'h40000000;
      d1 = -1; d2 = -1;
      for (int i = 0; i < 80 && d2 < 0; i++) begin
         @(posedge clk); #1;
         if (dif.done === 1'b1) begin
            if (d1 < 0) d1 = i; else d2 = i;
         end
      end
      dif.start = 1'b0;
      chk("b2b.first", 32'(d1), 32'd27);
      chk("b2b.gap", 32'(d2 - d1), 32'd28);
      repeat (32) @(posedge clk); #1;
      chk("b2b.idle", {31'b0, dif.busy}, 32'h0);

      for (int n = 0; n < 40; n++) begin
         ra = rnd_op();
         rb = rnd_op();
         ref_div(ra, rb, er, efl, elat);
         run($sformatf("rnd%0d", n), ra, rb, er, efl, elat);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fp_divider.md
# fp_divider

Sequential IEEE-754 single-precision divider: the inverse operation of `fp_multiplier`, sharing its operand/result/flag conventions and `start`-driven operation. It computes `inputA / inputB` with a restoring mantissa divider, one quotient bit per cycle, and rounds to nearest-even. It sits beside `fp_multiplier` in the FP datapath and returns a one-cycle `done` pulse with registered result and exception flags.

## Interface
- `BIAS`, 127: exponent bias. Only 127 is supported; the width is fixed at 8-bit exponent and 23-bit fraction.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `inputA`  in  32  dividend, IEEE-754 single.
- `inputB`  in  32  divisor, IEEE-754 single.
- `result`  out  32  quotient; registered, held until the next completion.
- `of`  out  1  overflow flag; registered with `result`.
- `uf`  out  1  underflow flag; registered with `result`.
- `dz`  out  1  divide-by-zero flag; registered with `result`.
- `busy`  out  1  high while not in IDLE.
- `done`  out  1  one-cycle pulse at the edge where `result` and the flags update.

## Operation
- States and transitions:
  - IDLE: `start` with a special case goes to IDLE (result written directly); `start` with normal operands goes to DIVIDE.
  - DIVIDE: 26 iterations, then NORM.
  - NORM goes to IDLE.
- Operands are latched at acceptance. Later changes to `inputA`/`inputB` have no effect.
- Denormal inputs (exp = 0) are treated as zero. Sign = signA ^ signB for all non-NaN results.
- Special cases, in priority order:
  - either operand NaN, 0/0, or inf/inf: result 0x7FC00000, no flags.
  - A inf: result ±inf.
  - B zero: result ±inf, `dz`=1.
  - A zero or B inf: result ±0.
- Normal path:
  - Mantissas are mA = {1,fracA} and mB = {1,fracB}.
  - Restoring division produces q[25:0], where q[25] has weight 2^0, plus remainder `rem`.
  - Exponent e = eA − eB + BIAS, held as a 10-bit signed value.
- Normalization and rounding:
  - If q[25]=1: m = q[25:2], guard = q[1], sticky = q[0] | (rem≠0).
  - Otherwise: m = q[24:1], guard = q[0], sticky = (rem≠0), and e = e − 1.
  - Round-to-nearest-even: increment m when guard & (sticky | m[0]).
  - If the increment carries out (m = 2.0), set m = 1.0 and e = e + 1.
- Final exponent check:
  - e ≥ 255: result ±inf (0x7F800000 | sign), `of`=1.
  - e ≤ 0: result ±0, `uf`=1. Results are flushed; no denormals are produced.
- Each completion clears any flag that does not apply to it.

## Timing
- Reset values: `result`=0, `of`=`uf`=`dz`=0, `busy`=0, `done`=0, state IDLE.
- Latency is counted from edge k, where `start` is sampled high in IDLE:
  - Normal operands: DIVIDE occupies edges k+1..k+26, and NORM registers the outputs at edge k+27. `done` is high for the cycle after edge k+27. Latency is 27 cycles.
  - Special case: outputs are registered at edge k, and `done` is high in the following cycle.
- `start` while `busy` is ignored and not queued.
- `start` high in the cycle `done` is high is accepted, because the state is already IDLE.
- Holding `start` high continuously gives back-to-back operations.
- `rst` mid-operation aborts the division, returns to IDLE and clears all outputs. No `done` is produced.

## Structure
- Shared header `fp_defs.vh` holds constants also used by `fp_multiplier`: BIAS, QNAN = 0x7FC00000, POS_INF = 0x7F800000, field widths, and state encodings.
- Sub-module `fp_mant_divider` implements the 26-step restoring divider:
  - inputs `load`, `mA`, `mB`; outputs `q`, `rem_nz`, `valid`.
  - It owns its own iteration counter.
- The top level owns the FSM, special-case decode, exponent arithmetic, rounding and flags.

## Test plan
- 7.0 / 2.0 (A = 0x40E00000, B = 0x40000000): result 0x40600000, flags 0, `done` 27 cycles after the `start` edge; `busy` high throughout.
- 1.0 / 3.0 (A = 0x3F800000, B = 0x40400000): result 0x3EAAAAAB, which checks RNE round-up. −7.0 / 2.0 (A = 0xC0E00000): result 0xC0600000.
- Specials:
  - 1.0 / 0 gives 0x7F800000 with `dz`=1, `done` one cycle after acceptance.
  - 0 / 0 gives 0x7FC00000.
  - 0x7FC00000 / 1.0 gives 0x7FC00000.
  - 0 / 5.0 gives 0x00000000.
- Range:
  - 0x7F000000 / 0x3E800000 gives 0x7F800000 with `of`=1.
  - 0x00800000 / 0x40000000 gives 0x00000000 with `uf`=1.
  - a following normal divide clears both flags.
- Control:
  - A second `start` at cycle 5 of an operation is ignored; the first result is unchanged.
  - `rst` at cycle 10 clears `busy`, and no `done` is produced.
  - `start` held high gives back-to-back `done` pulses 28 cycles apart.
